collatz_sweep: RTL and testbench
================================

Name: collatz_sweep

Overview:
- Parametrised Collatz range engine: walks every seed in [seed_base, seed_base+seed_count-1] and computes each orbit length (steps to reach 1).
- Tracks the longest orbit and its seed, the global peak value reached, and sticky overflow/saturation flags.
- Core of the next-generation compute tile; a host-side I/O wrapper drives the start/abort handshake and samples the results.

Parameters:
- WIDTH, 64, iterator width in bits; all values are unsigned modulo 2^WIDTH.
- LEN_W, 16, orbit-length counter width.
- CNT_W, 16, seed-count width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  launches a sweep; sampled only in IDLE
- abort  in  1  stops a sweep in progress
- seed_base  in  WIDTH  first seed; captured on an accepted start
- seed_count  in  CNT_W  number of seeds; captured on an accepted start
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at the end of a sweep
- best_seed  out  WIDTH  seed with the longest valid orbit
- best_len  out  LEN_W  length of that orbit
- peak  out  WIDTH  largest iterator value held in RUN during the sweep
- ovf_flag  out  1  sticky: some seed computed 3n+1 >= 2^WIDTH
- ovf_seed  out  WIDTH  first seed that overflowed
- sat_flag  out  1  sticky: some seed reached length 2^LEN_W-1 without reaching 1
- seeds_done  out  CNT_W  seeds completed so far

Behaviour:
- Reset: state IDLE; every output and internal register is 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 and seed_count!=0: capture base and count; clear best_seed, best_len, peak, flags, ovf_seed, seeds_done; load n=seed_base and len=0; enter RUN next cycle.
  - start=1 and seed_count==0: clear the same results; go to DONE, so done pulses the following cycle.
- RUN, one step per cycle, in priority order:
  - abort=1: go to IDLE; no done pulse; partial results stay visible.
  - n==1 or n==0: seed finishes with length len. Seed 0 gives length 0 and exists only via wrap-around.
  - n odd and 3n+1 >= 2^WIDTH: seed finishes as overflow. Set ovf_flag; ovf_seed takes this seed only if ovf_flag was 0. The seed is excluded from best.
  - len == 2^LEN_W-1: seed finishes as saturated. Set sat_flag; the seed is excluded from best.
  - Otherwise: n <= n even ? n>>1 : 3n+1; len <= len+1.
- Every RUN cycle: if n > peak, then peak <= n.
- Seed finish:
  - A valid seed updates best only if len > best_len strictly; on ties the earlier seed wins.
  - seeds_done increments.
  - If more seeds remain, load the next seed (wrapping modulo 2^WIDTH) with len=0 in the same cycle. There is no bubble, and the state stays RUN.
  - After the last seed, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Timing: a valid seed of length L occupies exactly L+1 RUN cycles. start is ignored outside IDLE.
- Results are stable from the done cycle until the next accepted start.
- reset mid-sweep has priority over everything and returns to the reset state.

Test Plan:
- WIDTH=64, base=27, count=1 -> done after 112 RUN cycles; best_seed=27, best_len=111, peak=9232, ovf_flag=0, seeds_done=1.
- base=1, count=10 -> 77 RUN cycles; best_seed=9, best_len=19, peak=52, seeds_done=10.
- base=12, count=2 (both length 9) -> best_seed=12, best_len=9 (tie keeps the earlier seed).
- WIDTH=8, base=27, count=2 -> seed 27 overflows at n=107; ovf_flag=1, ovf_seed=27, peak=214; best_seed=28, best_len=18.
- LEN_W=4, base=7, count=1 -> sat_flag=1, best_len=0, best_seed=0.
- Abort/misc: abort on the 5th RUN cycle of base=27 -> IDLE, no done, busy=0; count=0 -> done 2 cycles after start with all results 0; start pulsed while busy is ignored.

Source files
------------

// File: rtl/collatz_sweep_if.sv
// Host-facing bundle for the Collatz range engine: the start/abort handshake,
// the sweep range, and the accumulated sweep results.
interface collatz_sweep_if #(
    parameter int WIDTH = 64,
    parameter int LEN_W = 16,
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] seed_base;
    logic [CNT_W-1:0] seed_count;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] best_seed;
    logic [LEN_W-1:0] best_len;
    logic [WIDTH-1:0] peak;
    logic             ovf_flag;
    logic [WIDTH-1:0] ovf_seed;
    logic             sat_flag;
    logic [CNT_W-1:0] seeds_done;

    modport master (
        output start, abort, seed_base, seed_count,
        input  busy, done, best_seed, best_len, peak,
               ovf_flag, ovf_seed, sat_flag, seeds_done
    );

    modport slave (
        input  start, abort, seed_base, seed_count,
        output busy, done, best_seed, best_len, peak,
               ovf_flag, ovf_seed, sat_flag, seeds_done
    );
endinterface

// File: rtl/collatz_sweep.sv
// Collatz range engine: walks a block of consecutive seeds one orbit step per
// cycle, keeping the longest orbit, the peak iterate and overflow/saturation flags.
module collatz_sweep #(
    parameter int WIDTH = 64,
    parameter int LEN_W = 16,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    collatz_sweep_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] n;
    logic [LEN_W-1:0] len;
    logic [WIDTH-1:0] cur_seed;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] best_seed;
    logic [LEN_W-1:0] best_len;
    logic [WIDTH-1:0] peak;
    logic             ovf_flag;
    logic [WIDTH-1:0] ovf_seed;
    logic             sat_flag;
    logic [CNT_W-1:0] seeds_done;

    // Two extra bits on 3n+1 expose the carry out of the iterator width.
    logic [WIDTH+1:0] triple;
    logic [WIDTH-1:0] step_next;
    logic             is_end;
    logic             ovf_hit;
    logic             sat_hit;
    logic             finish;
    logic             last_seed;

    always_comb begin
        triple    = {2'b00, n} + {1'b0, n, 1'b0} + {{(WIDTH+1){1'b0}}, 1'b1};
        step_next = n[0] ? triple[WIDTH-1:0] : {1'b0, n[WIDTH-1:1]};
        is_end    = (n[WIDTH-1:1] == '0);
        ovf_hit   = !is_end && n[0] && (triple[WIDTH+1:WIDTH] != 2'b00);
        sat_hit   = !is_end && !ovf_hit && (&len);
        finish    = is_end || ovf_hit || sat_hit;
        last_seed = (seeds_done == count - CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) state_next = (bus.seed_count != '0) ? RUN : DONE;
            end
            RUN: begin
                if (bus.abort)                state_next = IDLE;
                else if (finish && last_seed) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n          <= '0;
            len        <= '0;
            cur_seed   <= '0;
            count      <= '0;
            best_seed  <= '0;
            best_len   <= '0;
            peak       <= '0;
            ovf_flag   <= 1'b0;
            ovf_seed   <= '0;
            sat_flag   <= 1'b0;
            seeds_done <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        n          <= bus.seed_base;
                        len        <= '0;
                        cur_seed   <= bus.seed_base;
                        count      <= bus.seed_count;
                        best_seed  <= '0;
                        best_len   <= '0;
                        peak       <= '0;
                        ovf_flag   <= 1'b0;
                        ovf_seed   <= '0;
                        sat_flag   <= 1'b0;
                        seeds_done <= '0;
                    end
                end
                RUN: begin
                    // The peak tracks every iterate held in RUN, including the abort cycle.
                    if (n > peak) peak <= n;
                    if (!bus.abort) begin
                        if (finish) begin
                            seeds_done <= seeds_done + CNT_W'(1);
                            if (is_end && (len > best_len)) begin
                                best_seed <= cur_seed;
                                best_len  <= len;
                            end
                            if (ovf_hit) begin
                                ovf_flag <= 1'b1;
                                if (!ovf_flag) ovf_seed <= cur_seed;
                            end
                            if (sat_hit) sat_flag <= 1'b1;
                            if (!last_seed) begin
                                cur_seed <= cur_seed + WIDTH'(1);
                                n        <= cur_seed + WIDTH'(1);
                                len      <= '0;
                            end
                        end else begin
                            n   <= step_next;
                            len <= len + LEN_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (state == RUN);
    assign bus.done       = (state == DONE);
    assign bus.best_seed  = best_seed;
    assign bus.best_len   = best_len;
    assign bus.peak       = peak;
    assign bus.ovf_flag   = ovf_flag;
    assign bus.ovf_seed   = ovf_seed;
    assign bus.sat_flag   = sat_flag;
    assign bus.seeds_done = seeds_done;
endmodule

// File: tb/tb_collatz_sweep.sv
// Bench for collatz_sweep: three instances (64-bit, 8-bit iterator, 4-bit length)
// checked against a plain-arithmetic orbit model with directed and random sweeps.
module tb_collatz_sweep;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  start_v;
    logic [2:0]  abort_v;
    logic [63:0] base_v;
    logic [15:0] count_v;
    int          sel;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    collatz_sweep_if #(.WIDTH(64), .LEN_W(16), .CNT_W(16)) if64 ();
    collatz_sweep_if #(.WIDTH(8),  .LEN_W(16), .CNT_W(16)) if8 ();
    collatz_sweep_if #(.WIDTH(64), .LEN_W(4),  .CNT_W(16)) if4 ();

    assign if64.start = start_v[0];
    assign if64.abort = abort_v[0];
    assign if64.seed_base = base_v;
    assign if64.seed_count = count_v;
    assign if8.start = start_v[1];
    assign if8.abort = abort_v[1];
    assign if8.seed_base = base_v[7:0];
    assign if8.seed_count = count_v;
    assign if4.start = start_v[2];
    assign if4.abort = abort_v[2];
    assign if4.seed_base = base_v;
    assign if4.seed_count = count_v;

    collatz_sweep #(.WIDTH(64), .LEN_W(16), .CNT_W(16)) dut64 (.clk(clk), .reset(reset), .bus(if64));
    collatz_sweep #(.WIDTH(8),  .LEN_W(16), .CNT_W(16)) dut8  (.clk(clk), .reset(reset), .bus(if8));
    collatz_sweep #(.WIDTH(64), .LEN_W(4),  .CNT_W(16)) dut4  (.clk(clk), .reset(reset), .bus(if4));

    logic        o_busy, o_done, o_ovf_flag, o_sat_flag;
    logic [63:0] o_best_seed, o_best_len, o_peak, o_ovf_seed, o_seeds_done;

    always_comb begin
        o_busy = if64.busy; o_done = if64.done;
        o_best_seed = if64.best_seed; o_best_len = 64'(if64.best_len);
        o_peak = if64.peak; o_ovf_flag = if64.ovf_flag; o_ovf_seed = if64.ovf_seed;
        o_sat_flag = if64.sat_flag; o_seeds_done = 64'(if64.seeds_done);
        if (sel == 1) begin
            o_busy = if8.busy; o_done = if8.done;
            o_best_seed = 64'(if8.best_seed); o_best_len = 64'(if8.best_len);
            o_peak = 64'(if8.peak); o_ovf_flag = if8.ovf_flag; o_ovf_seed = 64'(if8.ovf_seed);
            o_sat_flag = if8.sat_flag; o_seeds_done = 64'(if8.seeds_done);
        end else if (sel == 2) begin
            o_busy = if4.busy; o_done = if4.done;
            o_best_seed = if4.best_seed; o_best_len = 64'(if4.best_len);
            o_peak = if4.peak; o_ovf_flag = if4.ovf_flag; o_ovf_seed = if4.ovf_seed;
            o_sat_flag = if4.sat_flag; o_seeds_done = 64'(if4.seeds_done);
        end
    end

    typedef struct {
        logic [63:0] best_seed;
        logic [63:0] best_len;
        logic [63:0] peak;
        logic        ovf_flag;
        logic [63:0] ovf_seed;
        logic        sat_flag;
        logic [63:0] seeds_done;
        int          cycles;
    } result_t;

    // Orbit model in wide arithmetic: one loop pass per RUN cycle, overflow judged on the true 3n+1.
    function automatic result_t model(input logic [63:0] base, input int count,
                                      input int w, input int lw);
        result_t     r;
        logic [127:0] mask, lmax, seed, n, len, t;
        r = '{default: '0};
        mask = (128'd1 << w) - 128'd1;
        lmax = (128'd1 << lw) - 128'd1;
        seed = {64'd0, base} & mask;
        for (int i = 0; i < count; i++) begin
            n = seed;
            len = 0;
            for (int k = 0; k < 70000; k++) begin
                r.cycles++;
                if (n > {64'd0, r.peak}) r.peak = n[63:0];
                if (n <= 1) begin
                    if (len > {64'd0, r.best_len}) begin
                        r.best_len = len[63:0];
                        r.best_seed = seed[63:0];
                    end
                    break;
                end
                t = 3 * n + 1;
                if (n[0] && t > mask) begin
                    if (!r.ovf_flag) r.ovf_seed = seed[63:0];
                    r.ovf_flag = 1'b1;
                    break;
                end
                if (len == lmax) begin
                    r.sat_flag = 1'b1;
                    break;
                end
                n = n[0] ? t : (n >> 1);
                len++;
            end
            seed = (seed + 1) & mask;
        end
        r.seeds_done = 64'(count);
        return r;
    endfunction

    int got_cycles;
    bit got_done;
    bit timed_out;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Launch a sweep on instance s; optionally abort on a given RUN cycle or re-pulse start while busy.
    task automatic applyStimulus(input int s, input logic [63:0] base, input int count,
                                 input int abort_at, input int pulse_at);
        sel = s;
        @(negedge clk);
        base_v = base;
        count_v = count[15:0];
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
        got_cycles = 0;
        got_done = 0;
        timed_out = 1;
        for (int i = 0; i < 20000; i++) begin
            if (o_busy) got_cycles++;
            if (o_done) begin
                got_done = 1;
                timed_out = 0;
                break;
            end
            if (abort_at > 0 && got_cycles == abort_at) begin
                abort_v[s] = 1'b1;
                @(negedge clk);
                abort_v[s] = 1'b0;
                timed_out = 0;
                break;
            end
            if (pulse_at > 0 && got_cycles == pulse_at) begin
                base_v = 64'd5;
                count_v = 16'd3;
                start_v[s] = 1'b1;
            end else begin
                start_v[s] = 1'b0;
            end
            @(negedge clk);
        end
        start_v[s] = 1'b0;
    endtask

    task automatic checkSweep(input string tag, input result_t e);
        checkOutput({tag, "_timeout"}, 64'(timed_out), 64'd0);
        checkOutput({tag, "_cycles"}, 64'(got_cycles), 64'(e.cycles));
        checkOutput({tag, "_best_seed"}, o_best_seed, e.best_seed);
        checkOutput({tag, "_best_len"}, o_best_len, e.best_len);
        checkOutput({tag, "_peak"}, o_peak, e.peak);
        checkOutput({tag, "_ovf_flag"}, 64'(o_ovf_flag), 64'(e.ovf_flag));
        checkOutput({tag, "_ovf_seed"}, o_ovf_seed, e.ovf_seed);
        checkOutput({tag, "_sat_flag"}, 64'(o_sat_flag), 64'(e.sat_flag));
        checkOutput({tag, "_seeds_done"}, o_seeds_done, e.seeds_done);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 64'(o_done), 64'd0);
        checkOutput({tag, "_stable_len"}, o_best_len, e.best_len);
    endtask

    initial begin
        result_t e;
        logic [63:0] rb;
        int rc;
        sel = 0;
        reset = 1'b1;
        start_v = '0;
        abort_v = '0;
        base_v = '0;
        count_v = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", 64'(o_busy), 64'd0);
        checkOutput("rst_done", 64'(o_done), 64'd0);
        checkOutput("rst_peak", o_peak, 64'd0);
        checkOutput("rst_seeds_done", o_seeds_done, 64'd0);
        checkOutput("rst_best_seed", o_best_seed, 64'd0);

        applyStimulus(0, 64'd27, 1, 0, 0);
        checkOutput("s27_cycles_const", 64'(got_cycles), 64'd112);
        checkOutput("s27_len_const", o_best_len, 64'd111);
        checkOutput("s27_peak_const", o_peak, 64'd9232);
        checkSweep("s27", model(64'd27, 1, 64, 16));

        applyStimulus(0, 64'd1, 10, 0, 0);
        checkOutput("s1x10_cycles_const", 64'(got_cycles), 64'd77);
        checkOutput("s1x10_seed_const", o_best_seed, 64'd9);
        checkSweep("s1x10", model(64'd1, 10, 64, 16));

        applyStimulus(0, 64'd12, 2, 0, 0);
        checkOutput("tie_seed_const", o_best_seed, 64'd12);
        checkSweep("tie", model(64'd12, 2, 64, 16));

        applyStimulus(1, 64'd27, 2, 0, 0);
        checkOutput("w8_ovf_seed_const", o_ovf_seed, 64'd27);
        checkOutput("w8_peak_const", o_peak, 64'd214);
        checkOutput("w8_best_len_const", o_best_len, 64'd18);
        checkSweep("w8", model(64'd27, 2, 8, 16));

        applyStimulus(2, 64'd7, 1, 0, 0);
        checkOutput("l4_sat_const", 64'(o_sat_flag), 64'd1);
        checkSweep("l4", model(64'd7, 1, 64, 4));

        applyStimulus(0, 64'd27, 1, 5, 0);
        checkOutput("abort_busy", 64'(o_busy), 64'd0);
        checkOutput("abort_done", 64'(o_done), 64'd0);
        checkOutput("abort_peak", o_peak, 64'd124);
        checkOutput("abort_seeds_done", o_seeds_done, 64'd0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("abort_no_done", 64'(o_done), 64'd0);
        end

        applyStimulus(0, 64'd99, 0, 0, 0);
        checkOutput("zero_cycles", 64'(got_cycles), 64'd0);
        checkOutput("zero_done", 64'(got_done), 64'd1);
        checkOutput("zero_peak", o_peak, 64'd0);
        checkOutput("zero_best_len", o_best_len, 64'd0);

        applyStimulus(0, 64'd27, 1, 0, 10);
        checkSweep("restart_ignored", model(64'd27, 1, 64, 16));

        applyStimulus(1, 64'd254, 4, 0, 0);
        checkSweep("w8_wrap", model(64'd254, 4, 8, 16));

        for (int i = 0; i < 6; i++) begin
            rb = 64'($urandom_range(1, 3000));
            rc = $urandom_range(1, 6);
            applyStimulus(0, rb, rc, 0, 0);
            e = model(rb, rc, 64, 16);
            checkSweep($sformatf("rnd64_%0d", i), e);
        end
        for (int i = 0; i < 6; i++) begin
            rb = 64'($urandom_range(0, 255));
            rc = $urandom_range(1, 40);
            applyStimulus(1, rb, rc, 0, 0);
            e = model(rb, rc, 8, 16);
            checkSweep($sformatf("rnd8_%0d", i), e);
        end
        for (int i = 0; i < 3; i++) begin
            rb = 64'($urandom_range(1, 200));
            rc = $urandom_range(1, 8);
            applyStimulus(2, rb, rc, 0, 0);
            e = model(rb, rc, 64, 4);
            checkSweep($sformatf("rnd4_%0d", i), e);
        end

        sel = 0;
        @(negedge clk);
        base_v = 64'd27;
        count_v = 16'd1;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midrst_busy", 64'(o_busy), 64'd0);
        checkOutput("midrst_peak", o_peak, 64'd0);
        checkOutput("midrst_seeds_done", o_seeds_done, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
